// File: rtl/ser_add_pkg.sv
// Shared types and default sizing for the serial-add scheduler.
package ser_add_pkg;

  localparam int SER_WIDTH = 4;
  localparam int SER_NREQ  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ser_add_bit.sv
// One-bit full adder with a registered carry, stepped once per CALC cycle.
// s_bit and co are combinational from the current operand bits and stored carry.
module ser_add_bit (
  input  logic clk,
  input  logic reset,
  input  logic a_bit,
  input  logic b_bit,
  input  logic clr,
  input  logic en,
  output logic s_bit,
  output logic carry,
  output logic co
);

  assign s_bit = a_bit ^ b_bit ^ carry;
  assign co    = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));

  // Carry storage: cleared on reset or on a new accept, advanced while enabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      carry <= 1'b0;
    end else if (clr) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= co;
    end
  end

endmodule

// File: rtl/ser_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
//
// Handshakes: a transfer happens on a posedge where valid and ready are both
// high. req_ready is a one-hot grant computed from req_valid and the rotating
// pointer only; a requester may drop req_valid at any time before its transfer.
// resp_valid stays high with stable payload until resp_ready is seen with it.
module ser_add_sched
  import ser_add_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int NREQ  = SER_NREQ,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_cout,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   cur_id;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [IDW:0]     pick;
  logic [IDW-1:0]   g;
  logic             accept;
  logic             last;
  logic             s_bit, carry, co;

  // First requester with valid set, searching from p upward with wrap.
  // Returns {found, index}; iterating from the far end lets offset 0 win.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  p);
    logic [IDW:0]   r;
    logic [IDW-1:0] jj;
    int             j;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j  = (int'(p) + k) % NREQ;
      jj = IDW'(j);
      if (v[jj]) r = {1'b1, jj};
    end
    return r;
  endfunction

  assign pick       = rr_pick(req_valid, ptr);
  assign g          = pick[IDW-1:0];
  assign last       = (count == CW'(WIDTH - 1));
  assign sum_next   = WIDTH'({s_bit, sum_sh} >> 1);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  ser_add_bit u_bit (
    .clk   (clk),
    .reset (reset),
    .a_bit (a_sh[0]),
    .b_bit (b_sh[0]),
    .clr   (accept),
    .en    (state == CALC),
    .s_bit (s_bit),
    .carry (carry),
    .co    (co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, grant and accept strobe.
  always_comb begin
    state_n   = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (reset && pick[IDW]) begin
          req_ready[g] = 1'b1;
          accept       = 1'b1;
          state_n      = CALC;
        end
      end
      CALC: if (last) state_n = RESP;
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand load, serial shifting, result capture and pointer advance.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr       <= '0;
      cur_id    <= '0;
      count     <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
      resp_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= req_a[int'(g)*WIDTH +: WIDTH];
            b_sh   <= req_b[int'(g)*WIDTH +: WIDTH];
            count  <= '0;
            cur_id <= g;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          count  <= count + 1'b1;
          if (last) begin
            resp_sum  <= sum_next;
            resp_cout <= co;
            resp_id   <= cur_id;
          end
        end
        RESP: begin
          if (resp_ready) begin
            ptr <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_add_sched.sv
// Directed bench for ser_add_sched with hand-computed expected results.
module tb_ser_add_sched;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int W     = IDW + 1 + WIDTH;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WIDTH-1:0]      resp_sum;
  logic                  resp_cout;
  logic [IDW-1:0]        resp_id;
  logic                  busy;

  logic [W-1:0] exp_q[$];
  int           grant_q[$];
  int           n_chk;
  int           n_err;

  ser_add_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant log: every accepted request, in order.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic expect_resp(input int id, input logic [3:0] sum, input logic cout);
    exp_q.push_back({IDW'(id), cout, sum});
  endtask

  // Wait (bounded) for a response, score it, then complete the handshake.
  task automatic collect(output int waited);
    logic [W-1:0] e;
    waited = 0;
    while (!resp_valid && waited < 40) begin
      tick();
      waited++;
    end
    if (!resp_valid) begin
      check("resp_timeout", 32'(resp_valid), 32'd1);
    end else if (exp_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
      tick();
    end else begin
      e = exp_q.pop_front();
      check("resp_sum", 32'(resp_sum), 32'(e[WIDTH-1:0]));
      check("resp_cout", 32'(resp_cout), 32'(e[WIDTH]));
      check("resp_id", 32'(resp_id), 32'(e[W-1:WIDTH+1]));
      tick();
      check("resp_drop", 32'(resp_valid), 32'd0);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int w;
    int exp_ids[6];
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b1;

    // Reset state, with a request already pending.
    set_op(0, 4'h9, 4'h8);
    req_valid = 4'b0001;
    repeat (3) tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(resp_sum), 32'd0);
    check("rst_cout", 32'(resp_cout), 32'd0);
    check("rst_id", 32'(resp_id), 32'd0);

    // Single request: 9 + 8 = 0x11.
    expect_resp(0, 4'h1, 1'b1);
    reset = 1'b1;
    #1 check("t1_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check("t1_ready_low", 32'(req_ready), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    collect(w);
    check("t1_latency", 32'(1 + w), 32'd5);

    // Contention after reset: 0 first, then 2, pointer then at 3.
    pulse_reset();
    grant_q.delete();
    set_op(0, 4'h1, 4'h2);
    set_op(2, 4'h3, 4'h4);
    expect_resp(0, 4'h3, 1'b0);
    expect_resp(2, 4'h7, 1'b0);
    req_valid = 4'b0101;
    #1 check("t2_grant0", 32'(req_ready), 32'b0001);
    collect(w);
    check("t2_grant2", 32'(req_ready), 32'b0100);
    collect(w);
    req_valid = '0;
    check("t2_ngrants", 32'(grant_q.size()), 32'd2);
    if (grant_q.size() == 2) begin
      check("t2_first", 32'(grant_q[0]), 32'd0);
      check("t2_second", 32'(grant_q[1]), 32'd2);
    end
    req_valid = 4'b1111;
    #1 check("t2_ptr3", 32'(req_ready), 32'b1000);
    req_valid = '0;

    // Fairness: all four held, order 0,1,2,3,0,1.
    pulse_reset();
    grant_q.delete();
    set_op(0, 4'h1, 4'h1);
    set_op(1, 4'h7, 4'h9);
    set_op(2, 4'hA, 4'h3);
    set_op(3, 4'hC, 4'h6);
    expect_resp(0, 4'h2, 1'b0);
    expect_resp(1, 4'h0, 1'b1);
    expect_resp(2, 4'hD, 1'b0);
    expect_resp(3, 4'h2, 1'b1);
    expect_resp(0, 4'h2, 1'b0);
    expect_resp(1, 4'h0, 1'b1);
    exp_ids = '{0, 1, 2, 3, 0, 1};
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) collect(w);
    req_valid = '0;
    check("t3_ngrants", 32'(grant_q.size()), 32'd6);
    for (int k = 0; k < 6 && k < grant_q.size(); k++) begin
      check("t3_order", 32'(grant_q[k]), 32'(exp_ids[k]));
    end

    // Backpressure on requester 1: 6 + 5 = 0xB, held while resp_ready low.
    set_op(1, 4'h6, 4'h5);
    expect_resp(1, 4'hB, 1'b0);
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    w = 0;
    while (!resp_valid && w < 40) begin
      tick();
      w++;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      check("t4_valid", 32'(resp_valid), 32'd1);
      check("t4_sum", 32'(resp_sum), 32'hB);
      check("t4_id", 32'(resp_id), 32'd1);
      check("t4_ready", 32'(req_ready), 32'd0);
      check("t4_busy", 32'(busy), 32'd1);
      tick();
    end
    resp_ready = 1'b1;
    collect(w);
    req_valid = '0;
    tick();
    check("t4_single", 32'(resp_valid), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);

    // Reset during CALC (count==2) discards the operation.
    set_op(0, 4'hF, 4'h1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("t5_valid", 32'(resp_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_sum", 32'(resp_sum), 32'd0);
    check("t5_cout", 32'(resp_cout), 32'd0);
    check("t5_id", 32'(resp_id), 32'd0);
    reset = 1'b1;
    set_op(3, 4'h5, 4'hA);
    expect_resp(3, 4'hF, 1'b0);
    req_valid = 4'b1000;
    #1 check("t5_grant3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    collect(w);

    // Boundary operand values on requester 0, back to back.
    set_op(0, 4'hF, 4'h1);
    expect_resp(0, 4'h0, 1'b1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    collect(w);
    set_op(0, 4'hF, 4'hF);
    expect_resp(0, 4'hE, 1'b1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    collect(w);
    set_op(0, 4'h0, 4'h0);
    expect_resp(0, 4'h0, 1'b0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    collect(w);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ser_add_sched.md
Name: ser_add_sched

Overview:
- Round-robin scheduler that shares one bit-serial adder datapath among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants one requester, runs the LSB-first serial addition over WIDTH cycles, then returns sum, carry-out and requester id through a response handshake.
- It sits between the client blocks and the shared serial adder slice.

Parameters:
- WIDTH, 4, operand/sum width in bits; also the number of CALC cycles (legal range 2..16).
- NREQ, 4, number of requesters (legal range 2..8).
- IDW, 2, width of resp_id; must equal clog2(NREQ).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low; when low at a posedge, all state returns to reset values.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_sum  out  WIDTH  sum, mod 2^WIDTH.
- resp_cout  out  1  carry out of the MSB.
- resp_id  out  IDW  index of the serviced requester.
- busy  out  1  high in CALC and RESP.

Behaviour:
- Reset values:
  - state=IDLE, rr pointer ptr=0, count=0, carry=0, operand shift registers 0.
  - resp_valid=0, resp_sum=0, resp_cout=0, resp_id=0, busy=0.
  - req_ready is forced all-zero while reset is low.
- States: IDLE, CALC, RESP (one-hot or binary encoding, implementer's choice).
- IDLE:
  - Grant g is the first index with req_valid set, searching ptr, ptr+1, … NREQ-1, 0, … with wrap.
  - req_ready[g]=1 combinationally, from req_valid and ptr only; no dependence on operand values.
  - On an accept edge (req_valid[g] & req_ready[g]): latch req_a/req_b slice g into shift registers, carry=0, count=0, latch g as cur_id, go to CALC.
  - If no req_valid bit is set, stay in IDLE with req_ready=0.
- CALC (req_ready=0):
  - Each edge: {carry, sum_sh[MSB]} = a_sh[0] + b_sh[0] + carry.
  - sum_sh shifts right one bit; a_sh and b_sh shift right one bit; count = count+1.
  - On the edge where count==WIDTH-1: register resp_sum = final sum, resp_cout = final carry, resp_id = cur_id; go to RESP.
  - Exactly WIDTH CALC edges.
- Latency: resp_valid goes high WIDTH+1 edges after the accept edge (1 load edge + WIDTH calc edges).
- RESP:
  - resp_valid=1; resp_sum, resp_cout, resp_id held stable until the handshake.
  - resp_ready may stay low indefinitely.
  - On resp_valid & resp_ready: resp_valid=0, ptr = (cur_id+1) mod NREQ, go to IDLE.
  - Earliest next accept is the edge after the response handshake (no overlap).
  - resp_sum/resp_cout/resp_id keep their last values after the handshake; only resp_valid qualifies them.
- Request side rules:
  - req_valid may drop before grant without penalty; no latching of unaccepted requests.
  - Operand changes on a non-granted requester have no effect.
- Simultaneous events:
  - Multiple req_valid bits: rotating priority as above.
  - A request arriving on the response-handshake edge is considered in IDLE next cycle.
- Reset mid-operation (CALC or RESP): operation discarded, no response issued, ptr=0.
- Arithmetic: unsigned, carry-in always 0; overflow is reported only via resp_cout.
- busy = (state != IDLE).

Decomposition:
- Package ser_add_pkg:
  - state enum typedef {IDLE, CALC, RESP}.
  - Default constants SER_WIDTH=4, SER_NREQ=4.
- Sub-module ser_add_bit:
  - Registered 1-bit full adder: inputs a_bit, b_bit, clr, en; outputs s_bit, carry.
  - clr loads carry=0 on accept; en is high in CALC.
- Round-robin selection stays inline as a combinational function in ser_add_sched.

Test Plan:
- Single request: req_valid=4'b0001, a0=4'h9, b0=4'h8, resp_ready=1 -> req_ready=4'b0001 for one cycle; resp_valid 5 edges later with resp_sum=4'h1, resp_cout=1, resp_id=0.
- Contention after reset: req_valid=4'b0101 held (a2=4'h3, b2=4'h4) -> requester 0 serviced first, then req_ready=4'b0100; second response has resp_sum=4'h7, resp_cout=0, resp_id=2; ptr=3 afterwards.
- Fairness: all four req_valid held high continuously -> resp_id sequence 0,1,2,3,0,1; never two consecutive grants to the same requester.
- Backpressure: resp_ready low for 6 cycles in RESP -> resp_valid, resp_sum, resp_id stable; req_ready=0 throughout; busy=1; one response only after resp_ready rises.
- Reset mid-CALC: assert reset low at count==2 of a=4'hF, b=4'h1 -> next cycle resp_valid=0, busy=0, all outputs 0; a new request from requester 3 (a=4'h5, b=4'hA) -> resp_sum=4'hF, resp_cout=0, resp_id=3.
- Boundary values: a=4'hF, b=4'h1 -> sum 4'h0, cout 1; a=4'hF, b=4'hF -> sum 4'hE, cout 1; a=4'h0, b=4'h0 -> sum 0, cout 0 (checks the carry clear between operations).
